// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter among 2**ID_W byte requesters using a
//            rotating (round-robin) pointer. It drives the uart data /
//            dataReady / busy handshake for the granted requester. A byte is
//            abandoned if uart_busy never rises within BUSY_TIMEOUT cycles.
// Ports    : clk_50          - system clock (50 MHz)
//            reset_n         - asynchronous active-low reset
//            req_valid       - per-requester byte pending flag
//            req_data        - requester i byte at [8*i+7:8*i]
//            req_ack         - one-cycle pulse, requester byte captured
//            uart_data       - byte presented to the uart
//            uart_data_ready - uart dataReady
//            uart_busy       - uart busy
//            active_id       - index of the last granted requester
//            idle            - arbiter is in IDLE
//            timeout         - one-cycle pulse when a byte is abandoned
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int ID_W         = 2,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic                       clk_50,
    input  logic                       reset_n,
    input  logic [(1<<ID_W)-1:0]       req_valid,
    input  logic [8*(1<<ID_W)-1:0]     req_data,
    output logic [(1<<ID_W)-1:0]       req_ack,
    output logic [7:0]                 uart_data,
    output logic                       uart_data_ready,
    input  logic                       uart_busy,
    output logic [ID_W-1:0]            active_id,
    output logic                       idle,
    output logic                       timeout
);

    localparam int          c_num_req      = 1 << ID_W;
    localparam logic [15:0] c_timeout_last = 16'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_WAIT_BUSY     = 2'd1,
        ST_WAIT_NOT_BUSY = 2'd2
    } state_t;

    state_t                 r_state,     w_state_nxt;
    logic [7:0]             r_data,      w_data_nxt;
    logic                   r_ready,     w_ready_nxt;
    logic [c_num_req-1:0]   r_ack,       w_ack_nxt;
    logic [ID_W-1:0]        r_active_id, w_active_id_nxt;
    logic                   r_idle;
    logic                   r_timeout,   w_timeout_nxt;
    logic [15:0]            r_cnt,       w_cnt_nxt;

    logic                   w_found;
    logic [ID_W-1:0]        w_sel;
    logic [ID_W-1:0]        w_idx;

    // Round-robin search starting just after the last granted requester.
    // The ID_W-bit addition wraps naturally, giving the modulo NUM_REQ order;
    // the final step (k == NUM_REQ) revisits active_id itself last.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_active_id;
        w_idx   = r_active_id;
        for (int k = 1; k <= c_num_req; k++) begin
            w_idx = r_active_id + ID_W'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data;
        w_ready_nxt     = r_ready;
        w_ack_nxt       = '0;
        w_active_id_nxt = r_active_id;
        w_timeout_nxt   = 1'b0;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found && !uart_busy) begin
                    w_data_nxt       = req_data[8*w_sel +: 8];
                    w_ready_nxt      = 1'b1;
                    w_ack_nxt[w_sel] = 1'b1;
                    w_active_id_nxt  = w_sel;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (uart_busy) begin
                    w_ready_nxt = 1'b0;
                    w_state_nxt = ST_WAIT_NOT_BUSY;
                end else if (r_cnt == c_timeout_last) begin
                    // Dead transmitter: drop the byte, keep the pointer so
                    // rotation carries on from this requester.
                    w_ready_nxt   = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (r_cnt != 16'hFFFF) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            ST_WAIT_NOT_BUSY: begin
                if (!uart_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_ready     <= 1'b0;
            r_ack       <= '0;
            r_active_id <= '1;
            r_idle      <= 1'b1;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_data      <= w_data_nxt;
            r_ready     <= w_ready_nxt;
            r_ack       <= w_ack_nxt;
            r_active_id <= w_active_id_nxt;
            r_idle      <= (w_state_nxt == ST_IDLE);
            r_timeout   <= w_timeout_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign uart_data       = r_data;
    assign uart_data_ready = r_ready;
    assign req_ack         = r_ack;
    assign active_id       = r_active_id;
    assign idle            = r_idle;
    assign timeout         = r_timeout;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one UART transmitter among 2**ID_W byte requesters.
- Sits between producer blocks (message sequencers, status reporters) and the uart instance.
- Drives the uart data/dataReady/busy handshake on behalf of the granted requester.
- Guards against a dead transmitter with a busy-rise timeout.

Parameters:
- ID_W, 2, requester index width; NUM_REQ = 2**ID_W requesters (4 by default).
- BUSY_TIMEOUT, 1023, cycles to wait for uart_busy to rise before abandoning a byte; legal range 1..65535.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- reset_n  in  1  reset_n, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte-pending flag; held high until the matching req_ack.
- req_data  in  8*NUM_REQ  requester i byte at [8*i+7:8*i]; stable while req_valid[i] is high.
- req_ack  out  NUM_REQ  one-cycle pulse: requester's byte has been captured.
- uart_data  out  8  byte to the uart data input.
- uart_data_ready  out  1  to uart dataReady.
- uart_busy  in  1  from uart busy.
- active_id  out  ID_W  index of the last granted requester.
- idle  out  1  high when in IDLE.
- timeout  out  1  one-cycle pulse when a byte is abandoned.

Behaviour:
- Reset values (async on reset_n low):
  - uart_data=0, uart_data_ready=0, req_ack=0, timeout=0, idle=1.
  - active_id=NUM_REQ-1, so requester 0 has top priority first.
  - Timeout counter=0, state=IDLE.
- Reset mid-transfer aborts immediately to these values. The uart is reset by the same reset_n, so no resync is needed.
- States: IDLE, WAIT_BUSY, WAIT_NOT_BUSY. All outputs are registered.
- IDLE:
  - If any req_valid and !uart_busy: select the first set req_valid searching from active_id+1 upward, modulo NUM_REQ.
  - On the next edge:
    - uart_data <= selected byte.
    - uart_data_ready <= 1.
    - req_ack[sel] <= 1 for one cycle.
    - active_id <= sel.
    - counter <= 0.
    - state <= WAIT_BUSY.
  - Latency from req_valid high (arbiter idle) to uart_data_ready high: 1 cycle.
  - If uart_busy is high in IDLE, no grant is made; requests wait.
- WAIT_BUSY:
  - If uart_busy: uart_data_ready <= 0, state <= WAIT_NOT_BUSY.
  - Else if counter == BUSY_TIMEOUT-1: uart_data_ready <= 0, timeout pulse, state <= IDLE. The byte is dropped and not retried; active_id is kept, so rotation continues.
  - Else counter increments (16-bit, saturating, never wraps).
- WAIT_NOT_BUSY:
  - If !uart_busy: state <= IDLE.
  - No timeout here; uart transmit length is unbounded by this block.
- uart_data is held stable from capture until the next grant.
- Only one req_ack bit is ever high, and at most once per transfer.
- The requester drops req_valid or presents its next byte after the ack. The minimum 3-cycle IDLE-to-IDLE loop prevents double capture.
- Simultaneous requests are resolved purely by the rotating pointer. A requester holding req_valid continuously is served at most once per NUM_REQ grants while others wait.
- req_valid asserted in the same cycle as the IDLE return is eligible on that edge.
- idle = (state == IDLE).

Test Plan:
- Single request: req_valid[2]=1 with byte 0x51 ("Q"), uart model raises busy 2 cycles after dataReady and holds it 20 cycles.
  - Expect uart_data=0x51 and uart_data_ready one cycle after the request.
  - Expect one req_ack[2] pulse and active_id=2.
  - Expect uart_data_ready low the cycle after busy rises, and idle high after busy falls.
- All four requesters valid from reset with bytes 0x41..0x44, each dropping valid after its ack.
  - Expect the transmit order 0x41,0x42,0x43,0x44 (ids 0,1,2,3).
  - Expect exactly four acks and no duplicates.
- Fairness: requesters 0 and 3 held continuously valid for 8 transfers.
  - Expect strictly alternating grants 0,3,0,3,…
- Timeout: BUSY_TIMEOUT=8, uart_busy stuck low, req_valid[1]=1.
  - Expect uart_data_ready high for exactly 8 cycles, then one timeout pulse and a return to IDLE.
  - Expect req_ack[1] to have pulsed once at capture.
- Busy held high at reset release with requests pending.
  - Expect no grant until busy falls, then grant requester 0 on the next edge.
- reset_n pulsed low during WAIT_NOT_BUSY.
  - Expect all outputs at reset values immediately (async), and active_id=3.
  - After release with pending requests, expect requester 0 to be granted first.
